// File: rtl/painel_7seg.sv
// painel_7seg: registered multi-digit 7-segment driver for the DE0-CV HEX displays.
// Captures N_DIGITOS 5-bit codes on carrega, decodes each to an active-low glyph,
// with per-digit blinking from an internal divider and optional leading-zero blanking.
module painel_7seg #(
  parameter int N_DIGITOS = 6,
  parameter int DIV_PISCA = 25_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   carrega,
  input  logic [5*N_DIGITOS-1:0] valores,
  input  logic [N_DIGITOS-1:0]   piscar,
  input  logic                   suprime_zeros,
  output logic [7*N_DIGITOS-1:0] display,
  output logic                   fase_pisca
);

  localparam int unsigned    ND      = N_DIGITOS;
  localparam int             CW      = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV_PISCA - 1);
  localparam logic [6:0]     APAGADO = 7'b1111111;

  if (N_DIGITOS < 1 || N_DIGITOS > 8) begin : g_chk_digitos
    $error("painel_7seg: N_DIGITOS must be within 1..8");
  end
  if (DIV_PISCA < 2) begin : g_chk_div
    $error("painel_7seg: DIV_PISCA must be at least 2");
  end

  logic [5*N_DIGITOS-1:0] codigos;
  logic [CW-1:0]          cnt_pisca;
  logic [N_DIGITOS-1:0]   suprimido;
  logic [7*N_DIGITOS-1:0] prox_display;

  // Code glyph set, pattern g..a, active-low.
  function automatic logic [6:0] glifo(input logic [4:0] c);
    case (c)
      5'h00: glifo = 7'b1000000;
      5'h01: glifo = 7'b1111001;
      5'h02: glifo = 7'b0100100;
      5'h03: glifo = 7'b0110000;
      5'h04: glifo = 7'b0011001;
      5'h05: glifo = 7'b0010010;
      5'h06: glifo = 7'b0000010;
      5'h07: glifo = 7'b1111000;
      5'h08: glifo = 7'b0000000;
      5'h09: glifo = 7'b0010000;
      5'h0A: glifo = 7'b0001000;
      5'h0B: glifo = 7'b0000011;
      5'h0C: glifo = 7'b1000110;
      5'h0D: glifo = 7'b0100001;
      5'h0E: glifo = 7'b0000110;
      5'h0F: glifo = 7'b0001110;
      5'h10: glifo = 7'b1111110;
      5'h11: glifo = 7'b1111101;
      5'h12: glifo = 7'b1111011;
      5'h13: glifo = 7'b1110111;
      5'h14: glifo = 7'b1101111;
      5'h15: glifo = 7'b1011111;
      5'h16: glifo = 7'b0111111;
      5'h17: glifo = 7'b1111100;
      5'h18: glifo = 7'b1110011;
      5'h19: glifo = 7'b1100111;
      5'h1A: glifo = 7'b1001111;
      5'h1B: glifo = 7'b0011111;
      5'h1C: glifo = 7'b1110001;
      5'h1D: glifo = 7'b1100011;
      5'h1E: glifo = 7'b1000111;
      5'h1F: glifo = 7'b0001111;
      default: glifo = APAGADO;
    endcase
  endfunction

  // Code register: loaded on carrega, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset)
      codigos <= '0;
    else if (carrega)
      codigos <= valores;
  end

  // Blink divider: phase toggles on each counter wrap; reset restarts in the visible phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_pisca  <= '0;
      fase_pisca <= 1'b1;
    end else if (cnt_pisca == CNT_MAX) begin
      cnt_pisca  <= '0;
      fase_pisca <= ~fase_pisca;
    end else begin
      cnt_pisca  <= cnt_pisca + 1'b1;
    end
  end

  // Leading-zero scan from the top digit down; digit 0 is never suppressed.
  always_comb begin
    logic acima_zero;
    suprimido  = '0;
    acima_zero = suprime_zeros;
    for (int unsigned i = ND - 1; i >= 1; i--) begin
      acima_zero   = acima_zero & (codigos[5*i +: 5] == 5'd0);
      suprimido[i] = acima_zero;
    end
  end

  // Per-digit glyph selection: suppression, then blink, then decoded code.
  always_comb begin
    prox_display = '1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (suprimido[i])
        prox_display[7*i +: 7] = APAGADO;
      else if (piscar[i] && !fase_pisca)
        prox_display[7*i +: 7] = APAGADO;
      else
        prox_display[7*i +: 7] = glifo(codigos[5*i +: 5]);
    end
  end

  // Output register.
  always_ff @(posedge clock) begin
    if (reset)
      display <= '1;
    else
      display <= prox_display;
  end

endmodule

// File: tb/tb_painel_7seg.sv
// tb_painel_7seg: directed self-checking bench for painel_7seg (6 digits, DIV_PISCA=4).
module tb_painel_7seg;

  localparam int ND = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            carrega;
  logic [5*ND-1:0] valores;
  logic [ND-1:0]   piscar;
  logic            suprime_zeros;
  logic [7*ND-1:0] display;
  logic            fase_pisca;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] Z  = 7'b1000000;

  logic [6:0] mapa [0:31] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
    7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111,
    7'b1101111, 7'b1011111, 7'b0111111, 7'b1111100,
    7'b1110011, 7'b1100111, 7'b1001111, 7'b0011111,
    7'b1110001, 7'b1100011, 7'b1000111, 7'b0001111
  };

  painel_7seg #(.N_DIGITOS(ND), .DIV_PISCA(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .carrega      (carrega),
    .valores      (valores),
    .piscar       (piscar),
    .suprime_zeros(suprime_zeros),
    .display      (display),
    .fase_pisca   (fase_pisca)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [6:0] d0_exp;
    int         espera;

    // Reset with carrega active and all-ones codes: reset must win.
    reset = 1'b1; carrega = 1'b1; valores = '1; piscar = '0; suprime_zeros = 1'b0;
    repeat (3) tick();
    chk("reset_display", 42'(display), {ND{BL}});
    chk("reset_fase", 42'(fase_pisca), 42'(1));
    reset = 1'b0; carrega = 1'b0;
    tick();
    chk("post_reset_zeros", 42'(display), {ND{Z}});

    // Full glyph map on digit 0.
    for (int c = 0; c < 32; c++) begin
      valores = '0;
      valores[4:0] = 5'(c);
      carrega = 1'b1;
      tick();
      carrega = 1'b0;
      tick();
      chk($sformatf("map_%0d", c), 42'(display[6:0]), 42'(mapa[c]));
    end
    chk("map_upper_digits", 42'(display[41:7]), 42'({5{Z}}));

    // carrega held high: display tracks valores two edges later.
    valores = {25'd0, 5'h09}; carrega = 1'b1;
    tick();
    valores = {25'd0, 5'h1C};
    tick();
    chk("hold_load_a", 42'(display), {{5{Z}}, 7'b0010000});
    valores = {25'd0, 5'h0A};
    tick();
    chk("hold_load_b", 42'(display), {{5{Z}}, 7'b1110001});
    carrega = 1'b0;

    // Leading-zero suppression.
    suprime_zeros = 1'b1;
    valores = {5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd2}; carrega = 1'b1;
    tick(); carrega = 1'b0; tick();
    chk("lz_mixed", 42'(display), {BL, BL, BL, 7'b1111000, Z, 7'b0100100});
    valores = '0; carrega = 1'b1;
    tick(); carrega = 1'b0; tick();
    chk("lz_all_zero", 42'(display), {BL, BL, BL, BL, BL, Z});
    valores = {5'd0, 5'd0, 5'd0, 5'd0, 5'h10, 5'd0}; carrega = 1'b1;
    tick(); carrega = 1'b0; tick();
    chk("lz_extended_not_zero", 42'(display), {BL, BL, BL, BL, 7'b1111110, Z});
    valores = '0; carrega = 1'b1;
    tick(); carrega = 1'b0; tick();

    // Suppressed digit with blink enabled stays blank through both phases.
    piscar = 6'b000010;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("prio_d1_%0d", k), 42'(display[13:7]), 42'(BL));
      chk($sformatf("prio_d0_%0d", k), 42'(display[6:0]), 42'(Z));
    end

    // Blink: reset, then load code 3 on digit 0 at release.
    suprime_zeros = 1'b0; piscar = 6'b000001;
    reset = 1'b1; carrega = 1'b1; valores = {25'd0, 5'd3};
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      carrega = 1'b0;
      chk($sformatf("blink_fase_%0d", k), 42'(fase_pisca), 42'(((k / 4) % 2) == 0));
      if (k >= 2) begin
        d0_exp = ((((k - 1) / 4) % 2) == 0) ? 7'b0110000 : BL;
        chk($sformatf("blink_d0_%0d", k), 42'(display[6:0]), 42'(d0_exp));
        chk($sformatf("blink_steady_%0d", k), 42'(display[41:7]), 42'({5{Z}}));
      end
    end

    // Reset mid-blink during the hidden phase.
    espera = 0;
    while (fase_pisca !== 1'b0 && espera < 20) begin
      tick();
      espera++;
    end
    chk("wait_fase0", 42'(fase_pisca), 42'(0));
    reset = 1'b1;
    tick();
    chk("mid_reset_fase", 42'(fase_pisca), 42'(1));
    chk("mid_reset_display", 42'(display), {ND{BL}});
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("restart_fase_%0d", k), 42'(fase_pisca), 42'(k < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
